// File: rtl/serial_sub4.sv
// Bit-serial LSB-first subtractor: d = a - b - bin over WIDTH cycles using one
// full-subtractor cell, a borrow flop and a start/busy/done handshake.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q, d_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, bout_q, done_q, busy_q;

    logic             x, y, diff_bit, br_d;
    logic [WIDTH-1:0] r_sh_d;

    // Single full-subtractor cell shared across all bit positions.
    always_comb begin
        x        = a_sh_q[0];
        y        = b_sh_q[0];
        diff_bit = x ^ y ^ br_q;
        br_d     = (~x & y) | (~(x ^ y) & br_q);
        r_sh_d   = {diff_bit, r_sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bin;
                        r_sh_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    r_sh_q <= r_sh_d;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + 1'b1;
                    // Last bit: publish the result including this bit's diff/borrow.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        d_q     <= r_sh_d;
                        bout_q  <= br_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
endmodule
